ts_io_master: RTL
=================

TS_IO_MASTER -- requirements
Module: ts_io_master

Interface
REQ-001 Parameter: NUM_SLAVES, default 8, number of one-hot io_sel outputs (1..16).
REQ-002 Parameter: SEL_BITS, default 3, width of slave index taken from cmd_addr[16+SEL_BITS-1:16].
REQ-003 Parameter: TIMEOUT_CYCLES, default 255, read-ack wait limit in io_clk cycles (1..65535).
REQ-004 Port: io_clk  input  1  sole clock, all logic rising-edge.
REQ-005 Port: reset_n  input  1  synchronous, active-low reset.
REQ-006 Port: cmd_valid  input  1  command present.
REQ-007 Port: cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at a rising edge.
REQ-008 Port: cmd_rd  input  1  1 = read, 0 = write.
REQ-009 Port: cmd_addr  input  32  [31:16] slave select, [15:0] slave-local address.
REQ-010 Port: cmd_wr_data  input  32  write data.
REQ-011 Port: rsp_valid  output  1  response present.
REQ-012 Port: rsp_ready  input  1  response consumed when rsp_valid & rsp_ready at a rising edge.
REQ-013 Port: rsp_data  output  32  read data; 0 for writes.
REQ-014 Port: rsp_err  output  1  1 = bad address or read timeout.
REQ-015 Port: io_sel  output  NUM_SLAVES  one-hot slave select.
REQ-016 Port: io_sync  output  1  one-cycle transaction strobe.
REQ-017 Port: io_addr  output  16  slave-local address.
REQ-018 Port: io_rd_en / io_wr_en  output  1 each  operation type.
REQ-019 Port: io_wr_data  output  32  write data.
REQ-020 Port: io_rd_data  input  32  OR-combined slave readback.
REQ-021 Port: io_rd_ack  input  1  OR-combined slave read acknowledge.

Function
REQ-022 FSM states: IDLE, SYNC, WAIT_ACK, RESP; cmd_ready = 1 only in IDLE.
REQ-023 IDLE + accepted cmd with valid address -> SYNC; command fields registered on the accepting edge.
REQ-024 Valid address: cmd_addr[31:16+SEL_BITS] == 0 and index < NUM_SLAVES; otherwise IDLE -> RESP with rsp_err=1, rsp_data=0, no bus activity.
REQ-025 SYNC lasts exactly one cycle with io_sync=1; write -> RESP, read -> WAIT_ACK.
REQ-026 io_sel, io_addr, io_rd_en, io_wr_en, io_wr_data registered outputs, driven from the SYNC cycle through the last WAIT_ACK cycle, all zero otherwise.
REQ-027 WAIT_ACK: io_rd_ack=1 captures io_rd_data into rsp_data on the same edge -> RESP, rsp_err=0.
REQ-028 Write latency: command accepted at edge N, io_sync high cycle N+1, rsp_valid high cycle N+2, rsp_data=0, rsp_err=0.
REQ-029 Read latency with slave ack one cycle after io_sync: io_sync cycle N+1, ack cycle N+2, rsp_valid cycle N+3.
REQ-030 RESP holds rsp_valid, rsp_data, rsp_err stable until rsp_ready; that edge -> IDLE; next command accepted no earlier than the following edge.
REQ-031 io_rd_ack outside WAIT_ACK (IDLE, SYNC, RESP, any write) ignored; no state or data change.
REQ-032 io_rd_data sampled only on the ack edge; all other values ignored.

Reset
REQ-033 reset_n=0 at a rising edge -> IDLE; cmd_ready=1 after reset; rsp_valid=0, rsp_data=0, rsp_err=0, io_sel=0, io_sync=0, io_addr=0, io_rd_en=0, io_wr_en=0, io_wr_data=0, timeout counter=0.
REQ-034 Reset mid-transaction aborts silently: no response issued; a late io_rd_ack after reset ignored.

Configuration
REQ-035 Macro TS_IO_MASTER_TIMEOUT_EN defined: WAIT_ACK counter clears on SYNC entry, increments each WAIT_ACK cycle; TIMEOUT_CYCLES consecutive WAIT_ACK cycles without ack -> RESP, rsp_err=1, rsp_data=32'hDEAD_BEEF, bus outputs zeroed next cycle; ack coincident with the expiring cycle wins (success).
REQ-036 Macro undefined: no counter logic, WAIT_ACK waits indefinitely for io_rd_ack; TIMEOUT_CYCLES unused.

Verification
REQ-037 Write cmd_addr=0x0003_1004, data=0x1234_5678 -> cycle N+1: io_sel=8'h08, io_addr=0x1004, io_wr_en=1, io_sync=1; cycle N+2: rsp_valid=1, rsp_err=0, rsp_data=0.
REQ-038 Read cmd_addr=0x0001_0010, slave acks cycle N+2 with 0xCAFE_0001 -> rsp_valid cycle N+3, rsp_data=0xCAFE_0001, rsp_err=0.
REQ-039 Read cmd_addr=0x0009_0000 (NUM_SLAVES=8) -> io_sync never asserted, rsp_valid next cycle, rsp_err=1, rsp_data=0.
REQ-040 TIMEOUT_EN defined, TIMEOUT_CYCLES=4, no ack -> rsp_err=1, rsp_data=0xDEAD_BEEF exactly 4 cycles after SYNC; ack injected 2 cycles later ignored.
REQ-041 rsp_ready held 0 for 10 cycles -> rsp outputs stable, cmd_ready=0, new cmd_valid not accepted until the edge after rsp_ready=1.
REQ-042 reset_n=0 during WAIT_ACK -> all outputs zero next cycle, cmd_ready=1, no rsp_valid; late ack produces no response.

Source files
------------

// File: rtl/ts_io_master.sv
// ts_io_master: single-outstanding command master driving a one-hot selected slave I/O bus (optional read timeout via TS_IO_MASTER_TIMEOUT_EN)
module ts_io_master #(
   parameter int NUM_SLAVES     = 8,
   parameter int SEL_BITS       = 3,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  io_clk,
   input  logic                  reset_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_rd,
   input  logic [31:0]           cmd_addr,
   input  logic [31:0]           cmd_wr_data,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_data,
   output logic                  rsp_err,
   output logic [NUM_SLAVES-1:0] io_sel,
   output logic                  io_sync,
   output logic [15:0]           io_addr,
   output logic                  io_rd_en,
   output logic                  io_wr_en,
   output logic [31:0]           io_wr_data,
   input  logic [31:0]           io_rd_data,
   input  logic                  io_rd_ack
);
   typedef enum logic [1:0] {IDLE, SYNC, WAIT_ACK, RESP} state_t;
   state_t state, state_nx;
   logic [SEL_BITS-1:0] idx;
   logic addr_ok, accept, ack, timeout, bus_clr;

   if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
      $error("ts_io_master: parameter out of range");
   end

   assign idx       = cmd_addr[16 +: SEL_BITS];
   assign addr_ok   = ((cmd_addr[31:16] >> SEL_BITS) == 16'd0) && (32'(idx) < 32'(NUM_SLAVES));
   assign accept    = (state == IDLE) && cmd_valid;
   assign ack       = (state == WAIT_ACK) && io_rd_ack;
   assign bus_clr   = ((state == SYNC) && !io_rd_en) || ack || timeout;
   assign cmd_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign io_sync   = (state == SYNC);

`ifdef TS_IO_MASTER_TIMEOUT_EN
   logic [15:0] cnt;
   assign timeout = (state == WAIT_ACK) && !io_rd_ack && (cnt == 16'(TIMEOUT_CYCLES - 1));
   // count consecutive WAIT_ACK cycles; zero while in SYNC so each read starts fresh
   always_ff @(posedge io_clk)
      if (!reset_n || state == SYNC) cnt <= '0;
      else if (state == WAIT_ACK) cnt <= cnt + 16'd1;
`else
   assign timeout = 1'b0;
`endif

   // state register
   always_ff @(posedge io_clk)
      state <= !reset_n ? IDLE : state_nx;

   // next-state: bad addresses skip the bus entirely, writes need no ack
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (cmd_valid) state_nx = addr_ok ? SYNC : RESP;
         SYNC:     state_nx = io_rd_en ? WAIT_ACK : RESP;
         WAIT_ACK: if (io_rd_ack || timeout) state_nx = RESP;
         RESP:     if (rsp_ready) state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   // bus outputs live from SYNC through the final WAIT_ACK cycle; response captured on completion
   always_ff @(posedge io_clk) begin
      if (!reset_n) begin
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
         io_sel     <= '0;
         io_addr    <= '0;
         io_rd_en   <= 1'b0;
         io_wr_en   <= 1'b0;
         io_wr_data <= '0;
      end else begin
         if (accept) begin
            rsp_data <= '0;
            rsp_err  <= !addr_ok;
            if (addr_ok) begin
               io_sel     <= NUM_SLAVES'(1) << idx;
               io_addr    <= cmd_addr[15:0];
               io_rd_en   <= cmd_rd;
               io_wr_en   <= !cmd_rd;
               io_wr_data <= cmd_wr_data;
            end
         end
         if (bus_clr) begin
            io_sel     <= '0;
            io_addr    <= '0;
            io_rd_en   <= 1'b0;
            io_wr_en   <= 1'b0;
            io_wr_data <= '0;
         end
         if (ack) begin
            rsp_data <= io_rd_data;
            rsp_err  <= 1'b0;
         end
         if (timeout) begin
            rsp_data <= 32'hDEAD_BEEF;
            rsp_err  <= 1'b1;
         end
         if (state == RESP && rsp_ready) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
         end
      end
   end
endmodule
